// File: rtl/serial_ripple_subtractor_if.sv
// Bus bundle for serial_ripple_subtractor.
// Optional feature macro: SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN adds the overflow signal.
//
// Handshake: the master raises start for one or more cycles with x, y and
// borrow_in valid alongside it; the block samples them on the first rising
// edge where it is idle (busy=0, done=0). There is no ready signal: start
// seen while busy or done is dropped, never queued. done pulses for exactly
// one cycle when z/borrow_out carry the new result, which then holds until
// the next done.
interface serial_ripple_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             borrow_in;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;
  logic             borrow_out;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;
`ifdef SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN
  logic             overflow;

  modport master (
    output start, borrow_in, x, y,
    input  z, borrow_out, busy, done, dbg_state, overflow
  );

  modport slave (
    input  start, borrow_in, x, y,
    output z, borrow_out, busy, done, dbg_state, overflow
  );
`else
  modport master (
    output start, borrow_in, x, y,
    input  z, borrow_out, busy, done, dbg_state
  );

  modport slave (
    input  start, borrow_in, x, y,
    output z, borrow_out, busy, done, dbg_state
  );
`endif
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple subtractor: computes x - y - borrow_in one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flop.
// Optional feature macro: SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN adds a signed
// two's-complement overflow output, loaded and held alongside z.
module serial_ripple_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  serial_ripple_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             b_q, b_d;
  logic             bo_q, bo_d;
  logic             busy_q;
  logic             done_q;
`ifdef SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN
  // Operand sign bits are kept separately because the shift registers
  // lose them as the operation proceeds.
  logic             xm_q, xm_d;
  logic             ym_q, ym_d;
  logic             ov_q, ov_d;
`endif

  logic             diff_bit;
  logic             borrow_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor cell on the current LSBs and the running borrow.
  always_comb begin
    diff_bit   = xs_q[0] ^ ys_q[0] ^ b_q;
    borrow_nxt = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & b_q);
    res_shift  = {diff_bit, res_q[WIDTH-1:1]};
    last_bit   = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and datapath updates; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    res_d   = res_q;
    z_d     = z_q;
    b_d     = b_q;
    bo_d    = bo_q;
`ifdef SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN
    xm_d    = xm_q;
    ym_d    = ym_q;
    ov_d    = ov_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          xs_d    = bus.x;
          ys_d    = bus.y;
          b_d     = bus.borrow_in;
          res_d   = '0;
          cnt_d   = '0;
`ifdef SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN
          xm_d    = bus.x[WIDTH-1];
          ym_d    = bus.y[WIDTH-1];
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        xs_d  = xs_q >> 1;
        ys_d  = ys_q >> 1;
        b_d   = borrow_nxt;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        // The final bit is folded straight into z so done lands WIDTH cycles after start.
        if (last_bit) begin
          z_d     = res_shift;
          bo_d    = borrow_nxt;
`ifdef SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN
          ov_d    = (xm_q != ym_q) && (diff_bit != xm_q);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; busy/done are registered decodes of the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      res_q   <= '0;
      z_q     <= '0;
      b_q     <= 1'b0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN
      xm_q    <= 1'b0;
      ym_q    <= 1'b0;
      ov_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      res_q   <= res_d;
      z_q     <= z_d;
      b_q     <= b_d;
      bo_q    <= bo_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
`ifdef SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      ov_q    <= ov_d;
`endif
    end
  end

  assign bus.z          = z_q;
  assign bus.borrow_out = bo_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.dbg_state  = state_q;
`ifdef SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN
  assign bus.overflow   = ov_q;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Testbench for serial_ripple_subtractor (WIDTH=8). Build with
// SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN defined to include overflow in the result vector.
module tb_serial_ripple_subtractor;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  serial_ripple_subtractor_if #(.WIDTH(W)) bus ();

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int tests_run = 0;
  int fails     = 0;

  // Result vector layout: {overflow, borrow_out, z}
  logic [W+1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                         input logic bv);
    logic [W:0] full;
    logic       ov;
    full = {1'b0, xv} - {1'b0, yv} - {{W{1'b0}}, bv};
    ov   = 1'b0;
`ifdef SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN
    ov   = (xv[W-1] != yv[W-1]) && (full[W-1] != xv[W-1]);
`endif
    return {ov, full[W], full[W-1:0]};
  endfunction

  function automatic logic [W+1:0] obs();
    logic ov;
    ov = 1'b0;
`ifdef SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN
    ov = bus.overflow;
`endif
    return {ov, bus.borrow_out, bus.z};
  endfunction

  // ---------------- driver tasks ----------------
  // Leaves the caller at the falling edge just after the start-sampling edge.
  task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.x         = xv;
    bus.y         = yv;
    bus.borrow_in = bv;
    exp_q.push_back(model(xv, yv, bv));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done; reports cycles since the start edge, busy cycles seen,
  // and whether z stayed put until done.
  task automatic wait_done(output int cyc, output int busy_n, output bit timed_out,
                           output bit held);
    logic [W-1:0] z0;
    z0        = bus.z;
    cyc       = 0;
    busy_n    = 0;
    timed_out = 1'b0;
    held      = 1'b1;
    while (bus.done !== 1'b1) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.z !== z0) held = 1'b0;
      if (cyc >= 4 * W) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs() !== '0 || {bus.busy, bus.done, bus.dbg_state} !== 4'b0) begin
      fails++;
      $display("FAIL reset_state: got res=%h busy=%b done=%b st=%0d, want all 0",
               obs(), bus.busy, bus.done, bus.dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc, bn;
    bit to, held;
    logic [W+1:0] e;
    send(8'h35, 8'h12, 1'b0);
    wait_done(cyc, bn, to, held);
    tests_run++;
    if (to || cyc != W) begin
      fails++;
      $display("FAIL basic_latency: got %0d cycles (timeout=%0b), want %0d", cyc, to, W);
    end
    tests_run++;
    if (bn != W) begin
      fails++;
      $display("FAIL basic_busy: busy high %0d cycles, want %0d", bn, W);
    end
    e = exp_q.pop_front();
    tests_run++;
    if (obs() !== e || bus.z !== 8'h23) begin
      fails++;
      $display("FAIL basic_result: got %h, want %h (z=23)", obs(), e);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0 || bus.dbg_state !== 2'd0) begin
      fails++;
      $display("FAIL done_one_cycle: done=%b st=%0d, want 0/0", bus.done, bus.dbg_state);
    end
  endtask

  task automatic test_borrow();
    int cyc, bn;
    bit to, held;
    logic [W+1:0] e;
    send(8'h00, 8'h01, 1'b0);
    wait_done(cyc, bn, to, held);
    e = exp_q.pop_front();
    tests_run++;
    if (to || obs() !== e || bus.z !== 8'hFF || bus.borrow_out !== 1'b1) begin
      fails++;
      $display("FAIL borrow_wrap: got %h (timeout=%0b), want %h", obs(), to, e);
    end
    send(8'h10, 8'h0F, 1'b1);
    wait_done(cyc, bn, to, held);
    e = exp_q.pop_front();
    tests_run++;
    if (to || obs() !== e || bus.z !== 8'h00 || bus.borrow_out !== 1'b0) begin
      fails++;
      $display("FAIL borrow_in_zero: got %h (timeout=%0b), want %h", obs(), to, e);
    end
    tests_run++;
    if (!held) begin
      fails++;
      $display("FAIL z_hold_shift: z changed during SHIFT, want held at previous result");
    end
  endtask

  task automatic test_ignore_start();
    int done_n, done_at, cyc, bn;
    bit to, held;
    logic [W+1:0] got, e;
    send(8'h5A, 8'h3C, 1'b0);
    done_n  = 0;
    done_at = -1;
    got     = '0;
    for (int c = 1; c <= W + 4; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_n++;
        done_at = c;
        got     = obs();
      end
      bus.start = (c == 2 || c == 5);
      if (c == 2 || c == 5) begin
        bus.x         = W'($urandom);
        bus.y         = W'($urandom);
        bus.borrow_in = ~bus.borrow_in;
      end
    end
    e = exp_q.pop_front();
    tests_run++;
    if (done_n != 1 || done_at != W) begin
      fails++;
      $display("FAIL ignore_start_done: %0d done pulses at cycle %0d, want 1 at %0d",
               done_n, done_at, W);
    end
    tests_run++;
    if (got !== e) begin
      fails++;
      $display("FAIL ignore_start_result: got %h, want %h", got, e);
    end
    tests_run++;
    if (obs() !== e) begin
      fails++;
      $display("FAIL result_hold_idle: got %h, want %h", obs(), e);
    end
    send(8'hC3, 8'h3C, 1'b1);
    wait_done(cyc, bn, to, held);
    e = exp_q.pop_front();
    tests_run++;
    if (to || cyc != W || obs() !== e) begin
      fails++;
      $display("FAIL start_after_done: got %h after %0d cycles, want %h after %0d",
               obs(), cyc, e, W);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bn, seen;
    bit to, held;
    logic [W+1:0] e;
    send(8'h77, 8'h11, 1'b0);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (obs() !== '0 || {bus.busy, bus.done, bus.dbg_state} !== 4'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got res=%h busy=%b done=%b st=%0d, want all 0",
               obs(), bus.busy, bus.done, bus.dbg_state);
    end
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_mid_abort: done/busy seen %0d cycles after reset, want 0", seen);
    end
    send(8'hAA, 8'h55, 1'b0);
    wait_done(cyc, bn, to, held);
    e = exp_q.pop_front();
    tests_run++;
    if (to || cyc != W || obs() !== e || bus.z !== 8'h55) begin
      fails++;
      $display("FAIL reset_mid_fresh: got %h after %0d cycles, want %h", obs(), cyc, e);
    end
  endtask

  task automatic test_overflow();
    int cyc, bn;
    bit to, held;
    logic [W+1:0] e;
    send(8'h80, 8'h01, 1'b0);
    wait_done(cyc, bn, to, held);
    e = exp_q.pop_front();
    tests_run++;
    if (to || obs() !== e || bus.z !== 8'h7F) begin
      fails++;
      $display("FAIL overflow_set: got %h, want %h", obs(), e);
    end
    send(8'h05, 8'h03, 1'b0);
    wait_done(cyc, bn, to, held);
    e = exp_q.pop_front();
    tests_run++;
    if (to || obs() !== e) begin
      fails++;
      $display("FAIL overflow_clear: got %h, want %h", obs(), e);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bn, n_bad;
    bit to, held;
    logic [W+1:0] e;
    logic [W-1:0] xv, yv;
    logic         bv;
    logic [W-1:0] bx[6] = '{8'hFF, 8'h00, 8'h7F, 8'h80, 8'hFF, 8'h00};
    logic [W-1:0] by[6] = '{8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h00, 8'h00};
    logic         bb[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 30; i++) begin
      if (i < 6) begin
        xv = bx[i];
        yv = by[i];
        bv = bb[i];
      end else begin
        xv = W'($urandom_range(0, (1 << W) - 1));
        yv = W'($urandom_range(0, (1 << W) - 1));
        bv = 1'($urandom_range(0, 1));
      end
      send(xv, yv, bv);
      wait_done(cyc, bn, to, held);
      e = exp_q.pop_front();
      n_bad = 0;
      tests_run++;
      if (to || cyc != W || bn != W || obs() !== e) begin
        fails++;
        $display("FAIL back_to_back[%0d]: x=%h y=%h b=%b got %h cyc=%0d busy=%0d, want %h cyc=%0d",
                 i, xv, yv, bv, obs(), cyc, bn, e, W);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.borrow_in = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    test_reset();
    test_basic();
    test_borrow();
    test_ignore_start();
    test_reset_mid();
    test_overflow();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/serial_ripple_subtractor.md
SERIAL_RIPPLE_SUBTRACTOR -- requirements
Module: serial_ripple_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..16).
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port borrow_in, input, 1, initial borrow; captured with the operands.
REQ-006 The block SHALL have ports x and y, input, WIDTH each, minuend and subtrahend; captured on the start edge.
REQ-007 The block SHALL have port z, output, WIDTH, registered difference x - y - borrow_in.
REQ-008 The block SHALL have port borrow_out, output, 1, registered final borrow.
REQ-009 The block SHALL have port busy, output, 1, high while in SHIFT.
REQ-010 The block SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at edge k, the block SHALL capture x, y and borrow_in into shift and borrow registers, clear the bit counter and enter SHIFT.
REQ-013 In SHIFT, each edge SHALL process one bit LSB-first: diff = xb^yb^b; next b = (~xb&yb)|(~(xb^yb)&b); diff shifts in at the MSB of the result shift register.
REQ-014 At edge k+WIDTH, after WIDTH SHIFT cycles, the block SHALL load z from the result register, load borrow_out from the final borrow and enter DONE.
REQ-015 done SHALL be high for exactly the one cycle spent in DONE; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-016 Latency from the start-sampling edge to done high SHALL be exactly WIDTH cycles; throughput SHALL be one operation per WIDTH+2 cycles.
REQ-017 start SHALL be ignored in SHIFT and DONE; no queuing of requests.
REQ-018 z and borrow_out SHALL hold their value until the next DONE entry, and SHALL NOT change during SHIFT.
REQ-019 Changes on x, y or borrow_in after the start edge SHALL NOT affect the result in flight.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH; borrow_out=1 iff unsigned x < y + borrow_in.
REQ-021 busy SHALL be a registered state decode: 1 in SHIFT only.

Reset
REQ-022 Asserting reset SHALL immediately force IDLE, counter 0, z=0, borrow_out=0, done=0 and busy=0, independent of clock.
REQ-023 Reset during SHIFT SHALL abort the operation with no done pulse; the first start after deassertion SHALL behave per REQ-012.

Configuration
REQ-024 With macro SERIAL_RIPPLE_SUBTRACTOR_OVERFLOW_EN defined, the block SHALL add output port overflow (1 bit) giving signed two's-complement overflow, computed as (x[MSB] != y[MSB]) && (z[MSB] != x[MSB]) on the captured operands.
REQ-025 overflow SHALL be loaded with z at DONE entry, held like z, and reset to 0.
REQ-026 Without the macro, the overflow port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-027 WIDTH=8; x=0x35, y=0x12, borrow_in=0, start pulse -> done exactly 8 cycles after the start edge, z=0x23, borrow_out=0, busy high for 8 cycles.
REQ-028 x=0x00, y=0x01, borrow_in=0 -> z=0xFF, borrow_out=1; x=0x10, y=0x0F, borrow_in=1 -> z=0x00, borrow_out=0.
REQ-029 Start pulses at cycles 2 and 5 after the first start, and x/y toggled during SHIFT -> only one done and an unchanged result; the next start is accepted in IDLE after DONE.
REQ-030 Reset asserted mid-SHIFT (after 3 bits) -> outputs 0 immediately, no done; a fresh x=0xAA, y=0x55 -> z=0x55, borrow_out=0.
REQ-031 With OVERFLOW_EN: x=0x80, y=0x01 -> z=0x7F, overflow=1; x=0x05, y=0x03 -> overflow=0. Without the macro, the same bench minus overflow checks passes.
